security_keypad_ctrl: RTL

PIN-entry keypad controller that drives the `arm` and `disarm` command inputs of `home_security`. It is the initiator side of that command interface. It collects a digit sequence from a keypad scanner, checks it against a parameterised PIN on a command key, and emits single-cycle `arm`/`disarm` pulses. Repeated wrong PINs lock the keypad out.

---
 rtl/home_security_pkg.sv | 24 ++
 rtl/keypad_pin_buffer.sv | 56 +++++
 rtl/security_keypad_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/home_security_pkg.sv
// Shared keypad definitions: key codes, keypad FSM states and counter sizing helpers.
package home_security_pkg;

  localparam logic [3:0] KEY_ARM    = 4'hA;
  localparam logic [3:0] KEY_DISARM = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    CHECK   = 2'd2,
    LOCKOUT = 2'd3
  } kp_state_e;

  // Bits needed for a down-counter that is loaded with n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_pin_buffer.sv
// Digit entry buffer: newest digit in the LSB nibble, saturating count, PIN compare.
module keypad_pin_buffer
  import home_security_pkg::*;
#(
  parameter int          PIN_DIGITS = 4,
  parameter logic [31:0] PIN        = 32'h0000_1234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_i,
  input  logic       digit_valid_i,
  input  logic       clear_i,
  output logic       match_o,
  output logic [3:0] digit_cnt_o
);

  localparam int         W    = PIN_DIGITS * 4;
  localparam logic [3:0] FULL = 4'(PIN_DIGITS);

  logic [W-1:0] buf_q, buf_d;
  logic [3:0]   cnt_q, cnt_d;

  // Shift in digits until full; one extra digit marks overflow and freezes the buffer.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      buf_d = {W{1'b0}};
      cnt_d = 4'd0;
    end else if (digit_valid_i) begin
      if (cnt_q < FULL) begin
        buf_d = W'({buf_q, digit_i});
        cnt_d = cnt_q + 4'd1;
      end else begin
        cnt_d = FULL + 4'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Buffer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= {W{1'b0}};
      cnt_q <= 4'd0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign match_o     = (cnt_q == FULL) && (buf_q == PIN[W-1:0]);
  assign digit_cnt_o = cnt_q;

endmodule

// File: rtl/security_keypad_ctrl.sv
// PIN-entry keypad controller issuing arm/disarm pulses with failure lockout.
// Optional inter-key entry timeout is enabled by defining KEYPAD_TIMEOUT_EN.
module security_keypad_ctrl
  import home_security_pkg::*;
#(
  parameter int          PIN_DIGITS     = 4,
  parameter logic [31:0] PIN            = 32'h0000_1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          TIMEOUT_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       arm,
  output logic       disarm,
  output logic       armed,
  output logic       err,
  output logic       lockout,
  output logic [3:0] digit_cnt
);

  if (PIN_DIGITS < 1 || PIN_DIGITS > 8) begin : g_bad_pin_digits
    $error("PIN_DIGITS must be 1..8");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
    $error("MAX_TRIES must be 1..15");
  end
  if (LOCKOUT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("LOCKOUT_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  localparam int          LW          = cnt_width(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_RELOAD = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]  MAX_FAILS   = 4'(MAX_TRIES);

  kp_state_e     state_q, state_d;
  logic          cmd_arm_q, cmd_arm_d;
  logic [3:0]    fail_q, fail_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          arm_q, arm_d, disarm_q, disarm_d, err_q, err_d;
  logic          armed_q, armed_d, lockout_q, lockout_d;
  logic          key_dig_s, key_cmd_s, key_clr_s;
  logic          buf_push_s, buf_clear_s, match_s;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int            TW        = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_RELOAD = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  assign key_dig_s = key_valid && is_digit(key_code);
  assign key_cmd_s = key_valid && ((key_code == KEY_ARM) || (key_code == KEY_DISARM));
  assign key_clr_s = key_valid && (key_code == KEY_CLEAR);

  keypad_pin_buffer #(
    .PIN_DIGITS (PIN_DIGITS),
    .PIN        (PIN)
  ) u_pin_buffer (
    .clk           (clk),
    .rst_n         (reset),
    .digit_i       (key_code),
    .digit_valid_i (buf_push_s),
    .clear_i       (buf_clear_s),
    .match_o       (match_s),
    .digit_cnt_o   (digit_cnt)
  );

  // Next-state, command evaluation and lockout/timeout counting.
  always_comb begin
    state_d     = state_q;
    cmd_arm_d   = cmd_arm_q;
    fail_d      = fail_q;
    lock_cnt_d  = lock_cnt_q;
    armed_d     = armed_q;
    lockout_d   = lockout_q;
    arm_d       = 1'b0;
    disarm_d    = 1'b0;
    err_d       = 1'b0;
    buf_push_s  = 1'b0;
    buf_clear_s = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      IDLE, ENTRY: begin
        if (key_clr_s) begin
          buf_clear_s = 1'b1;
          state_d     = IDLE;
        end else if (key_cmd_s) begin
          cmd_arm_d = (key_code == KEY_ARM);
          state_d   = CHECK;
        end else if (key_dig_s) begin
          buf_push_s = 1'b1;
          state_d    = ENTRY;
`ifdef KEYPAD_TIMEOUT_EN
          to_cnt_d   = TO_RELOAD;
`endif
        end
`ifdef KEYPAD_TIMEOUT_EN
        // A key on the expiry cycle wins over the timeout.
        else if (state_q == ENTRY) begin
          if (to_cnt_q == {TW{1'b0}}) begin
            buf_clear_s = 1'b1;
            state_d     = IDLE;
          end else begin
            to_cnt_d = to_cnt_q - TW'(1);
          end
        end
`endif
        else begin
          state_d = state_q;
        end
      end
      CHECK: begin
        buf_clear_s = 1'b1;
        state_d     = IDLE;
        if (match_s) begin
          fail_d = 4'd0;
          if (cmd_arm_q) begin
            if (!armed_q) begin
              arm_d   = 1'b1;
              armed_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (armed_q) begin
              disarm_d = 1'b1;
              armed_d  = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
        end else begin
          err_d  = 1'b1;
          fail_d = fail_q + 4'd1;
          if ((fail_q + 4'd1) >= MAX_FAILS) begin
            state_d    = LOCKOUT;
            lockout_d  = 1'b1;
            lock_cnt_d = LOCK_RELOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LOCKOUT: begin
        if (lock_cnt_q == {LW{1'b0}}) begin
          state_d   = IDLE;
          lockout_d = 1'b0;
          fail_d    = 4'd0;
        end else begin
          lock_cnt_d = lock_cnt_q - LW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        buf_clear_s = 1'b1;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cmd_arm_q  <= 1'b0;
      fail_q     <= 4'd0;
      lock_cnt_q <= {LW{1'b0}};
      arm_q      <= 1'b0;
      disarm_q   <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_arm_q  <= cmd_arm_d;
      fail_q     <= fail_d;
      lock_cnt_q <= lock_cnt_d;
      arm_q      <= arm_d;
      disarm_q   <= disarm_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
      lockout_q  <= lockout_d;
    end
  end

`ifdef KEYPAD_TIMEOUT_EN
  // Inter-key idle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= {TW{1'b0}};
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign arm     = arm_q;
  assign disarm  = disarm_q;
  assign err     = err_q;
  assign armed   = armed_q;
  assign lockout = lockout_q;

endmodule
